// File: rtl/dm_cache_core.sv
// rtl/dm_cache_core.sv - direct-mapped write-back cache core, one word per line
module dm_cache_core #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LINES  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_req_valid,
    input  logic                    core_req_we,
    input  logic [ADDR_WIDTH-1:0]   core_req_addr,
    input  logic [DATA_WIDTH-1:0]   core_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] core_req_wstrb,
    output logic                    core_req_ready,
    output logic                    core_resp_valid,
    output logic                    core_resp_is_write,
    output logic [DATA_WIDTH-1:0]   core_resp_rdata,
    output logic [1:0]              core_resp_resp,
    output logic                    mem_req_valid,
    output logic                    mem_req_we,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
    input  logic                    mem_req_ready,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_rdata,
    input  logic [1:0]              mem_resp_resp,
    output logic [15:0]             stat_hits,
    output logic [15:0]             stat_misses,
    output logic [2:0]              dbg_state
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_WB_REQ  = 3'd2,
        S_WB_WAIT = 3'd3,
        S_RF_REQ  = 3'd4,
        S_RF_WAIT = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t state, state_next;

    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q [NUM_LINES];

    logic                  req_we_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic [STRB_W-1:0]     req_wstrb_q;
    logic [1:0]            resp_code_q;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_WIDTH-1:0] line_data;
    logic                  line_valid;
    logic                  line_dirty;
    logic                  lookup_hit;
    logic                  mem_ok;

    assign req_idx    = req_addr_q[OFF_W +: IDX_W];
    assign req_tag    = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign line_tag   = tag_q[req_idx];
    assign line_data  = data_q[req_idx];
    assign line_valid = valid_q[req_idx];
    assign line_dirty = dirty_q[req_idx];
    assign lookup_hit = line_valid && (line_tag == req_tag);
    assign mem_ok     = (mem_resp_resp == 2'b00);
    assign dbg_state  = state;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_data,
        input logic [DATA_WIDTH-1:0] new_data,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_data;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) r[8*b +: 8] = new_data[8*b +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next         = state;
        core_req_ready     = 1'b0;
        core_resp_valid    = 1'b0;
        core_resp_is_write = 1'b0;
        core_resp_rdata    = '0;
        core_resp_resp     = 2'b00;
        mem_req_valid      = 1'b0;
        mem_req_we         = 1'b0;
        mem_req_addr       = '0;
        mem_req_wdata      = '0;
        mem_req_wstrb      = '0;
        case (state)
            S_IDLE: begin
                core_req_ready = 1'b1;
                if (core_req_valid) state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (lookup_hit)                    state_next = S_RESP;
                else if (line_valid && line_dirty) state_next = S_WB_REQ;
                else                               state_next = S_RF_REQ;
            end
            S_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {line_tag, req_idx, {OFF_W{1'b0}}};
                mem_req_wdata = line_data;
                mem_req_wstrb = '1;
                if (mem_req_ready) state_next = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                if (mem_resp_valid) state_next = mem_ok ? S_RF_REQ : S_RESP;
            end
            S_RF_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                if (mem_req_ready) state_next = S_RF_WAIT;
            end
            S_RF_WAIT: begin
                if (mem_resp_valid) state_next = S_RESP;
            end
            S_RESP: begin
                core_resp_valid    = 1'b1;
                core_resp_is_write = req_we_q;
                core_resp_resp     = resp_code_q;
                // Writes and failed transactions return zero data.
                if (!req_we_q && resp_code_q == 2'b00) core_resp_rdata = line_data;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            stat_hits   <= '0;
            stat_misses <= '0;
            resp_code_q <= 2'b00;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core_req_valid) begin
                        req_we_q    <= core_req_we;
                        req_addr_q  <= core_req_addr;
                        req_wdata_q <= core_req_wdata;
                        req_wstrb_q <= core_req_wstrb;
                        resp_code_q <= 2'b00;
                    end
                end
                S_LOOKUP: begin
                    if (lookup_hit) begin
                        stat_hits <= stat_hits + 16'd1;
                        if (req_we_q) begin
                            data_q[req_idx]  <= merge_bytes(line_data, req_wdata_q, req_wstrb_q);
                            dirty_q[req_idx] <= 1'b1;
                        end
                    end else begin
                        stat_misses <= stat_misses + 16'd1;
                    end
                end
                S_WB_WAIT: begin
                    // A failed writeback leaves the victim intact and dirty.
                    if (mem_resp_valid) begin
                        if (mem_ok) dirty_q[req_idx] <= 1'b0;
                        else        resp_code_q      <= mem_resp_resp;
                    end
                end
                S_RF_WAIT: begin
                    if (mem_resp_valid) begin
                        if (mem_ok) begin
                            tag_q[req_idx]   <= req_tag;
                            valid_q[req_idx] <= 1'b1;
                            dirty_q[req_idx] <= req_we_q;
                            data_q[req_idx]  <= req_we_q
                                ? merge_bytes(mem_resp_rdata, req_wdata_q, req_wstrb_q)
                                : mem_resp_rdata;
                        end else begin
                            valid_q[req_idx] <= 1'b0;
                            dirty_q[req_idx] <= 1'b0;
                            resp_code_q      <= mem_resp_resp;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_cache_core.sv
// tb/tb_dm_cache_core.sv - randomized bench for dm_cache_core against an array-based cache model
module tb_dm_cache_core;
    localparam int NL = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req_valid, core_req_we;
    logic [31:0] core_req_addr, core_req_wdata;
    logic [3:0]  core_req_wstrb;
    logic        core_req_ready;
    logic        core_resp_valid, core_resp_is_write;
    logic [31:0] core_resp_rdata;
    logic [1:0]  core_resp_resp;
    logic        mem_req_valid, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [1:0]  mem_resp_resp;
    logic [15:0] stat_hits, stat_misses;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    dm_cache_core dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_we(core_req_we),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_req_wstrb(core_req_wstrb), .core_req_ready(core_req_ready),
        .core_resp_valid(core_resp_valid), .core_resp_is_write(core_resp_is_write),
        .core_resp_rdata(core_resp_rdata), .core_resp_resp(core_resp_resp),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_resp(mem_resp_resp),
        .stat_hits(stat_hits), .stat_misses(stat_misses), .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mtxn_t;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        m_valid [NL];
    logic        m_dirty [NL];
    logic [31:0] m_tag   [NL];
    logic [31:0] m_data  [NL];
    int          m_hits, m_misses;
    logic [31:0] mem [logic [31:0]];

    mtxn_t       got_txns[$];
    mtxn_t       exp_txns[$];
    logic [31:0] got_rdata;
    logic [1:0]  got_resp;
    logic        got_is_write;
    int          got_lat;
    int          stall_fixed = -1;
    int          stall_seen;
    bit          unstable;
    bit          spurious_en = 1'b0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h3C5A_9600;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [1:0] wb_err,
                             input logic [1:0] rf_err, input string name);
        int          idx, n, delay, stall_target, stall_cnt;
        logic [31:0] tag, la, exp_rdata;
        logic [1:0]  exp_resp;
        bit          exp_hit, wb_fail, pending, ready_leak, snap_valid;
        mtxn_t       snap, cur;
        logic [31:0] p_data;
        logic [1:0]  p_resp;

        // Reference prediction from cache rules
        exp_txns.delete();
        idx = int'((addr >> 2) % NL);
        tag = addr >> 6;
        la  = addr & ~32'h3;
        exp_hit = m_valid[idx] && (m_tag[idx] == tag);
        exp_rdata = 32'h0;
        exp_resp  = 2'b00;
        if (exp_hit) begin
            m_hits++;
            if (we) begin
                m_data[idx]  = merge(m_data[idx], wdata, strb);
                m_dirty[idx] = 1'b1;
            end else begin
                exp_rdata = m_data[idx];
            end
        end else begin
            m_misses++;
            wb_fail = 1'b0;
            if (m_valid[idx] && m_dirty[idx]) begin
                exp_txns.push_back('{1'b1, (m_tag[idx] << 6) | (32'(idx) << 2), m_data[idx], 4'hF});
                if (wb_err != 2'b00) begin
                    wb_fail  = 1'b1;
                    exp_resp = wb_err;
                end else begin
                    m_dirty[idx] = 1'b0;
                end
            end
            if (!wb_fail) begin
                exp_txns.push_back('{1'b0, la, 32'h0, 4'h0});
                if (rf_err == 2'b00) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tag;
                    m_data[idx]  = we ? merge(mem_read(la), wdata, strb) : mem_read(la);
                    m_dirty[idx] = we;
                    if (!we) exp_rdata = m_data[idx];
                end else begin
                    m_valid[idx] = 1'b0;
                    m_dirty[idx] = 1'b0;
                    exp_resp     = rf_err;
                end
            end
        end

        @(negedge clk);
        n_cmp++;
        if (core_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s.ready_idle got %b exp 1", name, core_req_ready);
        end
        core_req_valid = 1'b1;
        core_req_we    = we;
        core_req_addr  = addr;
        core_req_wdata = wdata;
        core_req_wstrb = strb;
        @(negedge clk);
        core_req_valid = 1'b0;
        core_req_we    = 1'b0;
        core_req_addr  = $urandom;
        core_req_wdata = $urandom;
        core_req_wstrb = 4'($urandom);
        got_txns.delete();
        n = 0; pending = 0; delay = 0; stall_cnt = 0; ready_leak = 0; snap_valid = 0;
        p_data = 32'h0; p_resp = 2'b00; snap = '0;
        stall_seen = 0; unstable = 0;
        stall_target = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 2));
        forever begin
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            if (core_resp_valid === 1'b1 || n >= 200) break;
            if (core_req_ready !== 1'b0) ready_leak = 1;
            if (pending) begin
                if (delay == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = p_data;
                    mem_resp_resp  = p_resp;
                    pending = 0;
                end else begin
                    delay--;
                end
            end else if (mem_req_valid === 1'b1) begin
                cur = '{mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb};
                if (!snap_valid) begin
                    snap = cur;
                    snap_valid = 1;
                end else if (cur !== snap) begin
                    unstable = 1;
                end
                if (stall_cnt < stall_target) begin
                    stall_cnt++;
                    if (stall_cnt > stall_seen) stall_seen = stall_cnt;
                end else begin
                    mem_req_ready = 1'b1;
                    got_txns.push_back(cur);
                    if (cur.we) begin
                        p_resp = wb_err;
                        p_data = $urandom;
                        if (wb_err == 2'b00) mem[cur.addr] = cur.wdata;
                    end else begin
                        p_resp = rf_err;
                        p_data = (rf_err == 2'b00) ? mem_read(cur.addr) : $urandom;
                    end
                    pending = 1;
                    delay = $urandom_range(0, 2);
                    stall_cnt = 0;
                    snap_valid = 0;
                    stall_target = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 2));
                end
            end else if (spurious_en && $urandom_range(0, 3) == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = $urandom;
                mem_resp_resp  = 2'($urandom);
            end
            @(negedge clk);
            n++;
        end
        got_lat      = n;
        got_rdata    = core_resp_rdata;
        got_resp     = core_resp_resp;
        got_is_write = core_resp_is_write;

        n_cmp++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL %s.timeout got no core_resp_valid exp response within 200 cycles", name);
        end
        n_cmp++;
        if (got_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s.rdata got %h exp %h", name, got_rdata, exp_rdata);
        end
        n_cmp++;
        if (got_resp !== exp_resp) begin
            n_fail++;
            $display("FAIL %s.resp got %b exp %b", name, got_resp, exp_resp);
        end
        n_cmp++;
        if (got_is_write !== we) begin
            n_fail++;
            $display("FAIL %s.is_write got %b exp %b", name, got_is_write, we);
        end
        n_cmp++;
        if (got_txns.size() != exp_txns.size()) begin
            n_fail++;
            $display("FAIL %s.mem_txn_count got %0d exp %0d", name, got_txns.size(), exp_txns.size());
        end else begin
            for (int i = 0; i < exp_txns.size(); i++) begin
                n_cmp++;
                if (got_txns[i] !== exp_txns[i]) begin
                    n_fail++;
                    $display("FAIL %s.mem_txn%0d got we=%b a=%h d=%h s=%h exp we=%b a=%h d=%h s=%h",
                             name, i, got_txns[i].we, got_txns[i].addr, got_txns[i].wdata,
                             got_txns[i].wstrb, exp_txns[i].we, exp_txns[i].addr,
                             exp_txns[i].wdata, exp_txns[i].wstrb);
                end
            end
        end
        n_cmp++;
        if (stat_hits !== 16'(m_hits) || stat_misses !== 16'(m_misses)) begin
            n_fail++;
            $display("FAIL %s.stats got h=%0d m=%0d exp h=%0d m=%0d", name, stat_hits, stat_misses,
                     16'(m_hits), 16'(m_misses));
        end
        if (exp_hit) begin
            n_cmp++;
            if (got_lat != 1) begin
                n_fail++;
                $display("FAIL %s.hit_latency got %0d exp 1 cycles after handshake cycle", name, got_lat);
            end
        end
        n_cmp++;
        if (ready_leak) begin
            n_fail++;
            $display("FAIL %s.ready_busy got 1 exp 0 while outstanding", name);
        end
        @(negedge clk);
        n_cmp++;
        if (core_resp_valid !== 1'b0 || core_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s.pulse got valid=%b ready=%b exp valid=0 ready=1", name,
                     core_resp_valid, core_req_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (core_req_ready !== 1'b1 || core_resp_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
            dbg_state !== 3'd0 || stat_hits !== 16'd0 || stat_misses !== 16'd0 ||
            (|{core_resp_is_write, core_resp_rdata, core_resp_resp, mem_req_we,
               mem_req_addr, mem_req_wdata, mem_req_wstrb}) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got ready=%b rv=%b mv=%b st=%0d h=%0d m=%0d exp ready=1 others 0",
                     name, core_req_ready, core_resp_valid, mem_req_valid, dbg_state,
                     stat_hits, stat_misses);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        core_req_valid = 0; core_req_we = 0; core_req_addr = 0; core_req_wdata = 0; core_req_wstrb = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0; mem_resp_resp = 0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_directed();
        mem[32'h40] = 32'hDEADBEEF;
        mem[32'h80] = 32'h0BADF00D;
        do_access(1'b0, 32'h40, 32'h0, 4'h0, 2'b00, 2'b00, "rd_miss_40");
        n_cmp++;
        if (got_rdata !== 32'hDEADBEEF || got_txns.size() != 1 || stat_misses !== 16'd1) begin
            n_fail++;
            $display("FAIL rd_miss_40.const got d=%h txns=%0d m=%0d exp DEADBEEF 1 1",
                     got_rdata, got_txns.size(), stat_misses);
        end
        do_access(1'b0, 32'h40, 32'h0, 4'h0, 2'b00, 2'b00, "rd_hit_40");
        n_cmp++;
        if (got_rdata !== 32'hDEADBEEF || got_txns.size() != 0 || stat_hits !== 16'd1) begin
            n_fail++;
            $display("FAIL rd_hit_40.const got d=%h txns=%0d h=%0d exp DEADBEEF 0 1",
                     got_rdata, got_txns.size(), stat_hits);
        end
        do_access(1'b1, 32'h40, 32'h11223344, 4'b0011, 2'b00, 2'b00, "wr_hit_40");
        do_access(1'b0, 32'h80, 32'h0, 4'h0, 2'b00, 2'b00, "rd_evict_80");
        n_cmp++;
        if (got_txns.size() != 2 ||
            got_txns[0] !== mtxn_t'({1'b1, 32'h40, 32'hDEAD3344, 4'hF})) begin
            n_fail++;
            $display("FAIL rd_evict_80.writeback got txns=%0d exp write 0x40 DEAD3344 then read 0x80",
                     got_txns.size());
        end
        do_access(1'b0, 32'hC0, 32'h0, 4'h0, 2'b00, 2'b10, "rd_err_c0");
        n_cmp++;
        if (got_resp !== 2'b10 || got_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_err_c0.const got r=%b d=%h exp 10 0", got_resp, got_rdata);
        end
        do_access(1'b0, 32'hC0, 32'h0, 4'h0, 2'b00, 2'b00, "rd_retry_c0");
        do_access(1'b1, 32'h44, 32'hCAFEF00D, 4'hF, 2'b00, 2'b00, "wr_miss_44");
        do_access(1'b0, 32'h84, 32'h0, 4'h0, 2'b11, 2'b00, "wb_err_84");
        do_access(1'b0, 32'h84, 32'h0, 4'h0, 2'b00, 2'b00, "wb_retry_84");
    endtask

    task automatic test_backpressure();
        stall_fixed = 5;
        do_access(1'b0, 32'h2000, 32'h0, 4'h0, 2'b00, 2'b00, "stall_2000");
        n_cmp++;
        if (unstable || stall_seen < 5) begin
            n_fail++;
            $display("FAIL stall_2000.stable got unstable=%b stalls=%0d exp 0 >=5", unstable, stall_seen);
        end
        stall_fixed = -1;
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 32'h3000;
        @(negedge clk);
        core_req_valid = 1'b0;
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        n_cmp++;
        if (dbg_state !== 3'd5) begin
            n_fail++;
            $display("FAIL rst_mid.rf_wait got state %0d exp 5", dbg_state);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_mid.idle");
        model_reset();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h12345678; mem_resp_resp = 2'b00;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (core_resp_valid !== 1'b0 || dbg_state !== 3'd0) begin
                n_fail++;
                $display("FAIL rst_mid.late_resp got rv=%b st=%0d exp 0 0", core_resp_valid, dbg_state);
            end
            @(negedge clk);
        end
        do_access(1'b0, 32'h40, 32'h0, 4'h0, 2'b00, 2'b00, "rst_mid.reread");
        n_cmp++;
        if (got_txns.size() != 1 || stat_misses !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_mid.invalid got txns=%0d m=%0d exp 1 1", got_txns.size(), stat_misses);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  we_err, rf_err;
        spurious_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, NL - 1) << 2) | $urandom_range(0, 3);
            we_err = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rf_err = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_access(1'($urandom), a, $urandom, 4'($urandom), we_err, rf_err, "random");
        end
        spurious_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_cache_core.md
DM_CACHE_CORE -- requirements
Module: dm_cache_core

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte address width.
REQ-002 Parameter DATA_WIDTH, 32, word and line width; one word per line.
REQ-003 Parameter NUM_LINES, 16, number of lines; power of two, at least 2.
REQ-004 Port clk  in  1  single clock; all logic on rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Ports core_req_valid/core_req_we/core_req_addr/core_req_wdata/core_req_wstrb  in  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  core request from the translator.
REQ-007 Port core_req_ready  out  1  request accepted when valid&&ready.
REQ-008 Ports core_resp_valid/core_resp_is_write/core_resp_rdata/core_resp_resp  out  1/1/DATA_WIDTH/2  one-cycle completion pulse.
REQ-009 Ports mem_req_valid/mem_req_we/mem_req_addr/mem_req_wdata/mem_req_wstrb  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  memory request.
REQ-010 Port mem_req_ready  in  1  memory accepts on valid&&ready.
REQ-011 Ports mem_resp_valid/mem_resp_rdata/mem_resp_resp  in  1/DATA_WIDTH/2  memory completion pulse.
REQ-012 Ports stat_hits/stat_misses  out  16/16  wrapping hit and miss counters.
REQ-013 Port dbg_state  out  3  current FSM state encoding.

Function
REQ-014 Address split: offset = low log2(DATA_WIDTH/8) bits; index = next log2(NUM_LINES) bits; tag = remaining bits.
REQ-015 Storage: per line valid, dirty, tag and data, all held in flops.
REQ-016 FSM states and encodings: IDLE=0, LOOKUP=1, WB_REQ=2, WB_WAIT=3, RF_REQ=4, RF_WAIT=5, RESP=6.
REQ-017 core_req_ready = (state==IDLE); on handshake latch we/addr/wdata/wstrb, go to LOOKUP.
REQ-018 LOOKUP hit (valid && tag match) -> RESP, stat_hits++.
- Read hit: response data = line data.
- Write hit: merge wdata per wstrb byte; set dirty.
REQ-019 LOOKUP miss -> stat_misses++, then:
- dirty victim -> WB_REQ.
- otherwise -> RF_REQ.
REQ-020 WB_REQ: drive a memory write.
- mem_req_we=1; addr={victim tag,index,0 offset}; wdata=victim data; wstrb all ones.
- On handshake -> WB_WAIT.
REQ-021 WB_WAIT on mem_resp_valid:
- resp OKAY -> clear dirty, go to RF_REQ.
- otherwise -> RESP with that code, rdata 0; line unchanged.
REQ-022 RF_REQ: drive a memory read.
- mem_req_we=1'b0; addr = request addr with offset zeroed; wstrb 0.
- On handshake -> RF_WAIT.
REQ-023 RF_WAIT on mem_resp_valid:
- resp OKAY -> install line: tag written, valid=1, data=mem_resp_rdata; write requests then merge wdata per wstrb and set dirty=1, reads leave dirty=0; go to RESP.
- resp non-OKAY -> valid=0, go to RESP with that code.
REQ-024 RESP:
- core_resp_valid=1 for exactly one cycle; is_write = latched we.
- rdata = line data for reads, 0 for writes and errors.
- Then go to IDLE.
REQ-025 Latency: read or write hit gives core_resp_valid exactly 2 cycles after the request handshake edge.
REQ-026 mem_req_valid=1 only in WB_REQ and RF_REQ; its fields stay stable until mem_req_ready.
REQ-027 mem_resp_valid outside WB_WAIT and RF_WAIT is ignored.
REQ-028 Only one request is outstanding at any time; core_req_ready stays 0 from the handshake through the RESP cycle.
REQ-029 Counters wrap 0xFFFF -> 0x0000.

Reset
REQ-030 With rst high at a clock edge, the block:
- enters IDLE;
- clears all valid and dirty bits and both counters;
- drives core_resp_valid=0, mem_req_valid=0, all other outputs 0, core_req_ready=1 on the next cycle.
Tag and data arrays are don't-care after reset.
REQ-031 Reset mid-transaction abandons the transaction; the memory response that arrives later is ignored.

Verification
REQ-032 Reset, then read 0x40 -> miss, no writeback; memory read addr 0x40; memory returns 0xDEADBEEF/OKAY -> core_resp rdata 0xDEADBEEF, resp 00, is_write 0, stat_misses=1.
REQ-033 Read 0x40 again -> hit; core_resp 2 cycles after handshake, rdata 0xDEADBEEF, no mem_req_valid, stat_hits=1.
REQ-034 Write 0x40, wdata 0x11223344, wstrb 4'b0011 -> hit; line becomes 0xDEAD3344 and dirty; is_write 1; no memory traffic.
REQ-035 Read 0x80 (index 0, new tag) -> memory write addr 0x40, data 0xDEAD3344, wstrb 4'hF; then memory read addr 0x80, in that order.
REQ-036 Refill returns resp 2'b10 -> core_resp_resp 2'b10, rdata 0; a repeat read of the same address misses again.
REQ-037 Two backpressure and reset cases:
- mem_req_ready held low 5 cycles -> mem_req fields stable, core_req_ready 0.
- rst in RF_WAIT -> next cycle IDLE, all lines invalid, and a late mem_resp_valid is ignored.
